// File: rtl/race_controller.sv
// Race sequencer: game tick, start countdown, pause, checkpoint/lap tracking for two cars, winner.
// Optional RACE_TIMER_EN adds a saturating race_time counter of ticks spent in RACE.
module race_controller #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_DIV = CLK_FREQ / 60,
  parameter int unsigned CD_SECS  = 3,
  parameter int unsigned NUM_LAPS = 3,
  parameter int unsigned FIN_X0   = 0,
  parameter int unsigned FIN_X1   = 20,
  parameter int unsigned FIN_Y0   = 100,
  parameter int unsigned FIN_Y1   = 140,
  parameter int unsigned CK_X0    = 140,
  parameter int unsigned CK_X1    = 180,
  parameter int unsigned CK_Y0    = 180,
  parameter int unsigned CK_Y1    = 239
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic        game_tick,
  output logic [2:0]  state,
  output logic [1:0]  countdown,
  output logic [2:0]  p1_lap,
  output logic [2:0]  p2_lap,
  output logic [1:0]  winner,
  output logic [15:0] race_time
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [2:0]    LAPS_WIN  = 3'(NUM_LAPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd2,
    S_RACE  = 3'd4,
    S_PAUSE = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d, pause_q, pause_d;
  logic          start_edge_q, start_edge_d, pause_edge_q, pause_edge_d;
  logic [9:0]    p1x_q, p1x_d, p1y_q, p1y_d, p2x_q, p2x_d, p2y_q, p2y_d;
  logic [1:0]    cd_q, cd_d;
  logic [5:0]    sub_q, sub_d;
  logic [2:0]    p1_lap_q, p1_lap_d, p2_lap_q, p2_lap_d;
  logic          p1_arm_q, p1_arm_d, p2_arm_q, p2_arm_d;
  logic [1:0]    winner_q, winner_d;
  logic          tick;
  logic          p1_done, p2_done;
`ifdef RACE_TIMER_EN
  logic [15:0]   rt_q, rt_d;
`endif

  function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic in_ck(input logic [9:0] x, input logic [9:0] y);
    return in_rng(x, 10'(CK_X0), 10'(CK_X1)) && in_rng(y, 10'(CK_Y0), 10'(CK_Y1));
  endfunction

  function automatic logic in_fin(input logic [9:0] x, input logic [9:0] y);
    return in_rng(x, 10'(FIN_X0), 10'(FIN_X1)) && in_rng(y, 10'(FIN_Y0), 10'(FIN_Y1));
  endfunction

  assign tick    = (cnt_q == '0);
  assign p1_done = (p1_lap_q == LAPS_WIN);
  assign p2_done = (p2_lap_q == LAPS_WIN);

  always_comb begin
    cnt_d        = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
    start_d      = start_btn;
    pause_d      = pause_btn;
    start_edge_d = start_btn & ~start_q;
    pause_edge_d = pause_btn & ~pause_q;
    p1x_d        = p1_x;
    p1y_d        = p1_y;
    p2x_d        = p2_x;
    p2y_d        = p2_y;
    state_d      = state_q;
    cd_d         = cd_q;
    sub_d        = sub_q;
    p1_lap_d     = p1_lap_q;
    p2_lap_d     = p2_lap_q;
    p1_arm_d     = p1_arm_q;
    p2_arm_d     = p2_arm_q;
    winner_d     = winner_q;
`ifdef RACE_TIMER_EN
    rt_d         = rt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_edge_q) begin
          state_d  = S_CD;
          cd_d     = 2'(CD_SECS);
          sub_d    = '0;
          p1_lap_d = '0;
          p2_lap_d = '0;
          p1_arm_d = 1'b0;
          p2_arm_d = 1'b0;
          winner_d = '0;
`ifdef RACE_TIMER_EN
          rt_d     = '0;
`endif
        end
      end
      S_CD: begin
        if (tick) begin
          if (sub_q == 6'd59) begin
            sub_d = '0;
            if (cd_q == 2'd1) begin
              state_d = S_RACE;
              cd_d    = '0;
            end else begin
              cd_d = cd_q - 1'b1;
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      S_RACE: begin
        // Pause wins over everything; a finished lap count ends the race one clock after the tick.
        if (pause_edge_q) begin
          state_d = S_PAUSE;
        end else if (p1_done || p2_done) begin
          state_d  = S_FIN;
          winner_d = {p2_done, p1_done};
        end else if (tick) begin
          if (in_ck(p1x_q, p1y_q)) begin
            p1_arm_d = 1'b1;
          end else if (in_fin(p1x_q, p1y_q) && p1_arm_q) begin
            p1_arm_d = 1'b0;
            if (p1_lap_q < LAPS_WIN) p1_lap_d = p1_lap_q + 1'b1;
          end
          if (in_ck(p2x_q, p2y_q)) begin
            p2_arm_d = 1'b1;
          end else if (in_fin(p2x_q, p2y_q) && p2_arm_q) begin
            p2_arm_d = 1'b0;
            if (p2_lap_q < LAPS_WIN) p2_lap_d = p2_lap_q + 1'b1;
          end
`ifdef RACE_TIMER_EN
          if (rt_q != 16'hFFFF) rt_d = rt_q + 1'b1;
`endif
        end
      end
      S_PAUSE: begin
        if (pause_edge_q) state_d = S_RACE;
      end
      S_FIN: begin
        if (start_edge_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      start_edge_q <= 1'b0;
      pause_edge_q <= 1'b0;
      p1x_q        <= '0;
      p1y_q        <= '0;
      p2x_q        <= '0;
      p2y_q        <= '0;
      cd_q         <= '0;
      sub_q        <= '0;
      p1_lap_q     <= '0;
      p2_lap_q     <= '0;
      p1_arm_q     <= 1'b0;
      p2_arm_q     <= 1'b0;
      winner_q     <= '0;
`ifdef RACE_TIMER_EN
      rt_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
      start_edge_q <= start_edge_d;
      pause_edge_q <= pause_edge_d;
      p1x_q        <= p1x_d;
      p1y_q        <= p1y_d;
      p2x_q        <= p2x_d;
      p2y_q        <= p2y_d;
      cd_q         <= cd_d;
      sub_q        <= sub_d;
      p1_lap_q     <= p1_lap_d;
      p2_lap_q     <= p2_lap_d;
      p1_arm_q     <= p1_arm_d;
      p2_arm_q     <= p2_arm_d;
      winner_q     <= winner_d;
`ifdef RACE_TIMER_EN
      rt_q         <= rt_d;
`endif
    end
  end

  assign game_tick = tick;
  assign state     = state_q;
  assign countdown = cd_q;
  assign p1_lap    = p1_lap_q;
  assign p2_lap    = p2_lap_q;
  assign winner    = winner_q;
`ifdef RACE_TIMER_EN
  assign race_time = rt_q;
`else
  assign race_time = 16'd0;
`endif
endmodule
